// File: rtl/microcode_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | microcode_sequencer: fetch sequence + per-opcode microcode stepper |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+

package microcode_pkg;
   typedef enum logic [4:0] {
      PC_to_MAR  = 5'd0,
      RAM_to_IR  = 5'd1,
      INC_PC     = 5'd2,
      RAM_to_MAR = 5'd3,
      MAR_to_RAM = 5'd4,
      ALU_ADD    = 5'd5,
      ALU_SUB    = 5'd6,
      A_to_B     = 5'd7,
      WAIT_CYCLE = 5'd8,
      WAIT_MT    = 5'd9,
      WAIT_UT    = 5'd10,
      WAIT_FT    = 5'd11,
      WAIT_DD    = 5'd12,
      WAIT_GPU   = 5'd13,
      HLT_CLK    = 5'd14,
      ENDMICRO   = 5'd15
   } Microcode_enum;
endpackage

module microcode_sequencer
   import microcode_pkg::*;
#(
   parameter int OPCODE_W = 8,
   parameter int STEP_W   = 4
) (
   input  logic                       clk,
   input  logic                       n_reset,
   input  logic [OPCODE_W-1:0]        ir_opcode,
   output logic [OPCODE_W+STEP_W-1:0] rom_addr,
   input  Microcode_enum              rom_data,
   input  logic                       busy_ms,
   input  logic                       busy_us,
   input  logic                       busy_ftu,
   input  logic                       busy_dd,
   input  logic                       busy_gpu,
   output Microcode_enum              current_microcode,
   output logic [STEP_W-1:0]          step,
   output logic                       in_fetch,
   output logic                       instr_done,
   output logic                       halted,
   output logic                       ucode_overrun
);

   typedef enum logic [2:0] {
      S_F0     = 3'd0,
      S_F1     = 3'd1,
      S_F2     = 3'd2,
      S_EXEC   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t            r_state, w_state_next;
   logic [STEP_W-1:0] r_step, w_step_next;
   logic              r_overrun, w_overrun_next;
   logic              w_wait_busy;
   logic              w_done;
   Microcode_enum     w_uc;

   // Only the busy line paired with the current wait code can stall.
   always_comb begin
      w_wait_busy = 1'b0;
      case (rom_data)
         WAIT_MT:  w_wait_busy = busy_ms;
         WAIT_UT:  w_wait_busy = busy_us;
         WAIT_FT:  w_wait_busy = busy_ftu;
         WAIT_DD:  w_wait_busy = busy_dd;
         WAIT_GPU: w_wait_busy = busy_gpu;
         default:  w_wait_busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state   <= S_F0;
         r_step    <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_step    <= w_step_next;
         r_overrun <= w_overrun_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_step_next    = r_step;
      w_overrun_next = r_overrun;
      w_done         = 1'b0;
      w_uc           = PC_to_MAR;
      case (r_state)
         S_F0: begin
            w_uc         = PC_to_MAR;
            w_state_next = S_F1;
         end
         S_F1: begin
            w_uc         = RAM_to_IR;
            w_state_next = S_F2;
         end
         S_F2: begin
            w_uc         = INC_PC;
            w_step_next  = '0;
            w_state_next = S_EXEC;
         end
         S_EXEC: begin
            w_uc = rom_data;
            if (rom_data == ENDMICRO) begin
               w_done       = 1'b1;
               w_step_next  = '0;
               w_state_next = S_F0;
            end else if (rom_data == HLT_CLK) begin
               w_state_next = S_HALTED;
            end else if (w_wait_busy) begin
               w_state_next = S_EXEC;
            end else if (&r_step) begin
               // Out of steps: finish the instruction rather than wrap.
               w_done         = 1'b1;
               w_overrun_next = 1'b1;
               w_step_next    = '0;
               w_state_next   = S_F0;
            end else begin
               w_step_next = r_step + STEP_W'(1);
            end
         end
         S_HALTED: begin
            w_uc         = HLT_CLK;
            w_state_next = S_HALTED;
         end
         default: begin
            w_uc         = PC_to_MAR;
            w_step_next  = '0;
            w_state_next = S_F0;
         end
      endcase
   end

   assign current_microcode = w_uc;
   assign instr_done        = w_done;
   assign halted            = (r_state == S_HALTED);
   assign in_fetch          = (r_state == S_F0) || (r_state == S_F1) || (r_state == S_F2);
   assign step              = r_step;
   assign rom_addr          = {ir_opcode, r_step};
   assign ucode_overrun     = r_overrun;

endmodule

`default_nettype wire

// File: doc/microcode_sequencer.md
# microcode_sequencer

Generates the `current_microcode` stream that the CPU microcode decoder turns into control strobes. It runs the fixed instruction-fetch sequence, then steps through the per-opcode microcode ROM until `ENDMICRO`. It holds on `WAIT_*` microcodes while the matching peripheral is busy, and parks permanently on `HLT_CLK`. It sits between the instruction register / microcode ROM and the decoder.

## Interface
Parameters:
- `OPCODE_W`, default 8: instruction-register opcode width.
- `STEP_W`, default 4: microcode step counter width; gives at most 2^STEP_W execute steps per instruction.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `n_reset`  in  1  reset, asynchronous and active-low.
- `ir_opcode`  in  OPCODE_W  opcode from the instruction register.
- `rom_addr`  out  OPCODE_W+STEP_W  microcode ROM address, `{ir_opcode, step}`.
- `rom_data`  in  Microcode_enum  combinational ROM output for `rom_addr`.
- `busy_ms`  in  1  millisecond timer running.
- `busy_us`  in  1  microsecond timer running.
- `busy_ftu`  in  1  frame-timing unit running.
- `busy_dd`  in  1  double-dabble BCD unit running.
- `busy_gpu`  in  1  GPU running.
- `current_microcode`  out  Microcode_enum  microcode executed this cycle; goes to the decoder.
- `step`  out  STEP_W  execute-step counter.
- `in_fetch`  out  1  high during the fetch states.
- `instr_done`  out  1  one-cycle pulse on the `ENDMICRO` cycle, or on a forced end.
- `halted`  out  1  high in the HALTED state.
- `ucode_overrun`  out  1  sticky flag: an instruction ran out of steps without reaching `ENDMICRO`.

## Operation
States are F0, F1, F2, EXEC and HALTED. `current_microcode` is combinational from the state:
- F0 emits `PC_to_MAR`.
- F1 emits `RAM_to_IR`.
- F2 emits `INC_PC`.
- EXEC emits `rom_data`.
- HALTED emits `HLT_CLK`.

Transitions:
- F0 -> F1 -> F2 -> EXEC, unconditionally, one cycle each. `step` is 0 on entry to EXEC.
- In EXEC, `rom_data` selects the next action:
  - `ENDMICRO`: assert `instr_done`, set `step` to 0, go to F0.
  - `HLT_CLK`: go to HALTED.
  - `WAIT_MT`, `WAIT_UT`, `WAIT_FT`, `WAIT_DD`, `WAIT_GPU`: hold state and `step` while the matching `busy_ms`, `busy_us`, `busy_ftu`, `busy_dd` or `busy_gpu` is 1. Advance on the first cycle it samples 0.
  - Any other code, including `WAIT_CYCLE`: `step` increments by 1.
- Step exhaustion: if `step` is at its maximum (all ones) and `rom_data` is not `ENDMICRO`, `HLT_CLK` or an active wait, the microcode still executes that cycle. Then `instr_done` pulses, `ucode_overrun` sets, `step` goes to 0 and the state goes to F0. `step` never wraps within an instruction.
- HALTED is absorbing. `busy_*` inputs are ignored. Only `n_reset` exits.
- A `busy_*` input that does not match the current wait code has no effect.

Other rules:
- `rom_addr` is always `{ir_opcode, step}`, including in fetch states; its value is don't-care outside EXEC.
- `ucode_overrun` clears only on reset.

## Timing
- Reset value while `n_reset` is 0:
  - state F0, so `current_microcode` = `PC_to_MAR`;
  - `step` = 0, `in_fetch` = 1;
  - `instr_done` = 0, `halted` = 0, `ucode_overrun` = 0.
- Reset is asynchronous. Asserting it mid-instruction, mid-wait or in HALTED returns to F0 immediately. The first fetch runs on the first `clk` edge after release.
- Instruction latency is 3 fetch cycles + N execute cycles, counting the `ENDMICRO` cycle, plus any wait cycles.
- Back-to-back instructions: the cycle after `ENDMICRO` is F0, with no bubble.
- A wait whose busy input is already 0 costs exactly 1 cycle.
- `instr_done` and `halted` are combinational from state and `rom_data`, and are valid in the same cycle as the microcode they describe.
- `ucode_overrun` is registered; it is visible from the cycle after the forced end.

## Test plan
- **Reset and fetch:** hold `n_reset`=0 → `PC_to_MAR`, `step`=0, `halted`=0, `ucode_overrun`=0. Release → `PC_to_MAR`, `RAM_to_IR`, `INC_PC` on three consecutive cycles, then EXEC with `rom_addr`=0x050 when `ir_opcode`=0x05.
- **Normal instruction:** opcode 0x05 ROM = {`RAM_to_MAR`, `ALU_ADD`, `ENDMICRO`} → `rom_addr` 0x050, 0x051, 0x052. `instr_done`=1 only on the 0x052 cycle. The next cycle is `PC_to_MAR`. Total 6 cycles.
- **Wait hold:** step 1 = `WAIT_MT`, `busy_ms`=1 for 4 cycles, `busy_gpu` toggling → `WAIT_MT` is shown for 5 cycles, `step` stays 1, then it advances to step 2. A wait with `busy_us`=0 lasts 1 cycle.
- **Halt:** step 0 = `HLT_CLK` → `halted`=1 from the next cycle and `HLT_CLK` persists for 100 cycles under any `busy_*` or `ir_opcode`. Pulsing `n_reset` → `PC_to_MAR`, `halted`=0.
- **Overrun:** with `STEP_W`=4, 16 consecutive `ALU_ADD` steps → after step 15, `instr_done` pulses, state returns to F0, and `ucode_overrun`=1 stays set through following good instructions until reset.
- **Reset mid-wait:** during `WAIT_GPU` with `busy_gpu`=1, assert `n_reset` asynchronously → `PC_to_MAR` and `step`=0 immediately, before the next `clk` edge.
